div_share_arbiter: RTL and testbench
====================================

// Module: div_share_arbiter
// PURPOSE
//  Shares one long-division datapath between two requesters, A and B, using round-robin arbitration.
//  - Latches the granted requester's operands and pulses div_start.
//  - Waits for div_done, then returns quotient/remainder/error to the owner with a one-cycle done pulse.
//  - Catches divide-by-zero before the divider runs; a watchdog catches a hung divider.
// PARAMETERS
//  SIZE     8    operand/result width, in bits
//  TIMEOUT  64   max cycles in BUSY without div_done before abort (>=2)
// PORTS
//  clk            in   1     system clock; all state updates on posedge
//  reset          in   1     asynchronous, active-low reset
//  req_a, req_b   in   1     division request; operands held stable until done_x
//  dividend_a     in   SIZE  requester A dividend
//  divisor_a      in   SIZE  requester A divisor
//  dividend_b     in   SIZE  requester B dividend
//  divisor_b      in   SIZE  requester B divisor
//  div_start      out  1     one-cycle start strobe to divider
//  div_dividend   out  SIZE  registered operand to divider
//  div_divisor    out  SIZE  registered operand to divider
//  div_quotient   in   SIZE  divider result; valid while div_done=1
//  div_remainder  in   SIZE  divider result; valid while div_done=1
//  div_done       in   1     divider completion strobe
//  div_error      in   1     divider error flag; valid with div_done
//  gnt_a, gnt_b   out  1     owner indication; high from ISSUE through RESP
//  done_a, done_b out  1     one-cycle completion pulse to owner
//  error_a        out  1     error status to A; valid with done_a
//  error_b        out  1     error status to B; valid with done_b
//  quotient_out   out  SIZE  shared result bus; held until next RESP
//  remainder_out  out  SIZE  shared result bus; held until next RESP
//  busy           out  1     state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async):
//  - state=IDLE, pri=A, owner=A, timer=0.
//  - All outputs 0, including buses and div_* registers.
//  FSM (registered, one-hot or binary): IDLE, ISSUE, BUSY, RESP.
//  IDLE:
//  - Both req high -> grant pri; one high -> grant it; none -> stay.
//  - On grant: owner<=winner, latch winner's operands into div_dividend/div_divisor, go ISSUE.
//  ISSUE:
//  - If div_divisor==0: no div_start, err<=1, q/r<=0, go RESP.
//  - Else div_start=1 for this cycle only, timer<=0, go BUSY.
//  BUSY:
//  - div_done=1 -> capture div_quotient/div_remainder/div_error, go RESP.
//  - Else timer++; at timer==TIMEOUT-1: err<=1, q/r<=0, go RESP.
//  - A late div_done after abort is ignored (arrives in RESP/IDLE).
//  RESP:
//  - done_owner=1 and error_owner=err; quotient_out/remainder_out driven.
//  - pri<=~owner, go IDLE.
//  - error_x and done_x for the non-owner stay 0.
//  Latency:
//  - Normal: grant at IDLE cycle t; div_start at t+1; done_x one cycle after div_done.
//  - Divide-by-zero: done_x at t+2.
//  Handshake:
//  - Requester drops req in the cycle after done_x. IDLE samples req combinationally.
//  - A req still high after done_x is re-granted only if the other requester is idle (pri favours the other).
//  Boundaries:
//  - req dropped mid-operation: operation completes; done_x still pulses.
//  - Operand change after grant: ignored (already latched).
//  - Simultaneous first requests after reset: A wins (pri=A).
//  - div_done while in ISSUE: ignored; divider contract forbids it.
//  - Async reset mid-BUSY: immediate return to reset values; div_start is not reissued.
// TESTING
//  1. A alone, 100/7, divider done after 9 cycles -> gnt_a, one div_start, done_a with q=14 r=2 error_a=0.
//  2. A and B both request from reset, A=50/5, B=9/4 -> A served first (q=10 r=0), then B (q=2 r=1).
//     Then both request again -> B first.
//  3. B request with divisor=0 -> no div_start, done_b at grant+2, error_b=1, q=r=0.
//  4. A request, divider never asserts done, TIMEOUT=64 -> done_a 64 cycles after div_start.
//     error_a=1; later div_done ignored; busy returns 0.
//  5. reset low during BUSY -> all outputs 0 same cycle.
//     After release, new A request restarts cleanly with a single div_start.

Source files
------------

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin arbiter sharing one long-division datapath
// between two requesters (A and B).
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   req_a/req_b                   division requests (operands stable until done_x)
//   dividend_a/divisor_a          requester A operands
//   dividend_b/divisor_b          requester B operands
//   div_start                     one-cycle start strobe to the divider
//   div_dividend/div_divisor      latched operands presented to the divider
//   div_quotient/div_remainder    divider results, valid with div_done
//   div_done/div_error            divider completion strobe and error flag
//   gnt_a/gnt_b                   owner indication, ISSUE through RESP
//   done_a/done_b                 one-cycle completion pulse to the owner
//   error_a/error_b               error status, valid with done_x
//   quotient_out/remainder_out    shared result bus, held until the next RESP
//   busy                          arbiter not idle
module div_share_arbiter #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_a,
  input  logic            req_b,
  input  logic [SIZE-1:0] dividend_a,
  input  logic [SIZE-1:0] divisor_a,
  input  logic [SIZE-1:0] dividend_b,
  input  logic [SIZE-1:0] divisor_b,
  output logic            div_start,
  output logic [SIZE-1:0] div_dividend,
  output logic [SIZE-1:0] div_divisor,
  input  logic [SIZE-1:0] div_quotient,
  input  logic [SIZE-1:0] div_remainder,
  input  logic            div_done,
  input  logic            div_error,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic            done_a,
  output logic            done_b,
  output logic            error_a,
  output logic            error_b,
  output logic [SIZE-1:0] quotient_out,
  output logic [SIZE-1:0] remainder_out,
  output logic            busy
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            pri_q, pri_d;      // 0: A favoured, 1: B favoured
  logic            owner_q, owner_d;  // 0: A, 1: B
  logic [TW-1:0]   timer_q, timer_d;
  logic            div_start_q, div_start_d;
  logic [SIZE-1:0] div_dividend_q, div_dividend_d;
  logic [SIZE-1:0] div_divisor_q, div_divisor_d;
  logic            gnt_a_q, gnt_a_d;
  logic            gnt_b_q, gnt_b_d;
  logic            done_a_q, done_a_d;
  logic            done_b_q, done_b_d;
  logic            error_a_q, error_a_d;
  logic            error_b_q, error_b_d;
  logic [SIZE-1:0] quotient_q, quotient_d;
  logic [SIZE-1:0] remainder_q, remainder_d;
  logic            busy_q, busy_d;

  // Response staging shared by the divide-by-zero, completion and timeout paths
  logic            resp_go;
  logic            resp_err;
  logic [SIZE-1:0] resp_quo;
  logic [SIZE-1:0] resp_rem;
  logic            win_b;

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    pri_d          = pri_q;
    owner_d        = owner_q;
    timer_d        = timer_q;
    div_start_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    gnt_a_d        = gnt_a_q;
    gnt_b_d        = gnt_b_q;
    done_a_d       = 1'b0;
    done_b_d       = 1'b0;
    error_a_d      = 1'b0;
    error_b_d      = 1'b0;
    quotient_d     = quotient_q;
    remainder_d    = remainder_q;
    resp_go        = 1'b0;
    resp_err       = 1'b0;
    resp_quo       = '0;
    resp_rem       = '0;
    win_b          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          win_b   = req_b && (!req_a || pri_q);
          owner_d = win_b;
          div_dividend_d = win_b ? dividend_b : dividend_a;
          div_divisor_d  = win_b ? divisor_b  : divisor_a;
          // Strobe is registered, so decide now whether ISSUE will start the divider
          div_start_d = win_b ? (divisor_b != '0) : (divisor_a != '0);
          gnt_a_d = !win_b;
          gnt_b_d = win_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (div_divisor_q == '0) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          timer_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (div_done) begin
          resp_go  = 1'b1;
          resp_err = div_error;
          resp_quo = div_quotient;
          resp_rem = div_remainder;
        end else if (timer_q == TW'(TIMEOUT - 2)) begin
          // This increment would reach TIMEOUT-1: abort so done lands TIMEOUT cycles after start
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          timer_d = TW'(timer_q + 1'b1);
        end
      end
      S_RESP: begin
        pri_d   = ~owner_q;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      state_d     = S_RESP;
      done_a_d    = !owner_q;
      done_b_d    = owner_q;
      error_a_d   = !owner_q && resp_err;
      error_b_d   = owner_q && resp_err;
      quotient_d  = resp_quo;
      remainder_d = resp_rem;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pri_q          <= 1'b0;
      owner_q        <= 1'b0;
      timer_q        <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      gnt_a_q        <= 1'b0;
      gnt_b_q        <= 1'b0;
      done_a_q       <= 1'b0;
      done_b_q       <= 1'b0;
      error_a_q      <= 1'b0;
      error_b_q      <= 1'b0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pri_q          <= pri_d;
      owner_q        <= owner_d;
      timer_q        <= timer_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      gnt_a_q        <= gnt_a_d;
      gnt_b_q        <= gnt_b_d;
      done_a_q       <= done_a_d;
      done_b_q       <= done_b_d;
      error_a_q      <= error_a_d;
      error_b_q      <= error_b_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      busy_q         <= busy_d;
    end
  end

  assign div_start     = div_start_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign gnt_a         = gnt_a_q;
  assign gnt_b         = gnt_b_q;
  assign done_a        = done_a_q;
  assign done_b        = done_b_q;
  assign error_a       = error_a_q;
  assign error_b       = error_b_q;
  assign quotient_out  = quotient_q;
  assign remainder_out = remainder_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed bench for div_share_arbiter; the bench plays
// the divider by driving div_done/div_quotient/div_remainder by hand.
module tb_div_share_arbiter;

  localparam int unsigned SIZE    = 8;
  localparam int unsigned TIMEOUT = 64;

  logic            clk;
  logic            reset;
  logic            req_a, req_b;
  logic [SIZE-1:0] dividend_a, divisor_a, dividend_b, divisor_b;
  logic            div_start;
  logic [SIZE-1:0] div_dividend, div_divisor;
  logic [SIZE-1:0] div_quotient, div_remainder;
  logic            div_done, div_error;
  logic            gnt_a, gnt_b, done_a, done_b, error_a, error_b;
  logic [SIZE-1:0] quotient_out, remainder_out;
  logic            busy;

  int n_cmp;
  int n_err;
  int n_start;
  int start_base;

  div_share_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_a        (req_a),
    .req_b        (req_b),
    .dividend_a   (dividend_a),
    .divisor_a    (divisor_a),
    .dividend_b   (dividend_b),
    .divisor_b    (divisor_b),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_done     (div_done),
    .div_error    (div_error),
    .gnt_a        (gnt_a),
    .gnt_b        (gnt_b),
    .done_a       (done_a),
    .done_b       (done_b),
    .error_a      (error_a),
    .error_b      (error_b),
    .quotient_out (quotient_out),
    .remainder_out(remainder_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which the divider sees a start strobe
  always @(negedge clk) if (div_start) n_start++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; land just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Hard stop if something goes badly wrong
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_start = 0;
    reset = 1'b0;
    req_a = 0; req_b = 0;
    dividend_a = '0; divisor_a = '0; dividend_b = '0; divisor_b = '0;
    div_quotient = '0; div_remainder = '0; div_done = 0; div_error = 0;
    tick();

    // Reset state
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_gnt_a", 32'(gnt_a), 0);
    check_eq("rst_start", 32'(div_start), 0);
    check_eq("rst_quo", 32'(quotient_out), 0);
    check_eq("rst_dvd", 32'(div_dividend), 0);
    reset = 1'b1;
    tick();

    // 1: A alone, 100/7, divider finishes 9 cycles after start
    start_base = n_start;
    req_a = 1; dividend_a = 8'd100; divisor_a = 8'd7;
    tick();  // ISSUE
    check_eq("t1_start", 32'(div_start), 1);
    check_eq("t1_gnt_a", 32'(gnt_a), 1);
    check_eq("t1_dvd", 32'(div_dividend), 100);
    check_eq("t1_dvs", 32'(div_divisor), 7);
    dividend_a = 8'd200;  // changed after grant, must be ignored
    repeat (8) tick();
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_dvd_hold", 32'(div_dividend), 100);
    div_done = 1; div_quotient = 8'd14; div_remainder = 8'd2;
    tick();  // RESP
    check_eq("t1_done_a", 32'(done_a), 1);
    check_eq("t1_done_b", 32'(done_b), 0);
    check_eq("t1_quo", 32'(quotient_out), 14);
    check_eq("t1_rem", 32'(remainder_out), 2);
    check_eq("t1_err_a", 32'(error_a), 0);
    div_done = 0; req_a = 0;
    tick();  // IDLE
    check_eq("t1_done_a_off", 32'(done_a), 0);
    check_eq("t1_busy_off", 32'(busy), 0);
    check_eq("t1_gnt_off", 32'(gnt_a), 0);
    check_eq("t1_quo_hold", 32'(quotient_out), 14);
    check_eq("t1_nstart", 32'(n_start - start_base), 1);

    // 2: simultaneous requests after reset; A first, A re-requests, B wins next
    do_reset();
    req_a = 1; dividend_a = 8'd50; divisor_a = 8'd5;
    req_b = 1; dividend_b = 8'd9;  divisor_b = 8'd4;
    tick();  // ISSUE for A
    check_eq("t2_gnt_a", 32'(gnt_a), 1);
    check_eq("t2_gnt_b", 32'(gnt_b), 0);
    check_eq("t2_dvd_a", 32'(div_dividend), 50);
    tick();  // BUSY
    div_done = 1; div_quotient = 8'd10; div_remainder = 8'd0;
    tick();  // RESP A
    check_eq("t2_done_a", 32'(done_a), 1);
    check_eq("t2_quo_a", 32'(quotient_out), 10);
    div_done = 0;
    tick();  // IDLE, both still requesting
    tick();  // ISSUE for B
    check_eq("t2_gnt_b2", 32'(gnt_b), 1);
    check_eq("t2_gnt_a2", 32'(gnt_a), 0);
    check_eq("t2_dvs_b", 32'(div_divisor), 4);
    check_eq("t2_start_b", 32'(div_start), 1);
    tick();  // BUSY
    div_done = 1; div_quotient = 8'd2; div_remainder = 8'd1;
    tick();  // RESP B
    check_eq("t2_done_b", 32'(done_b), 1);
    check_eq("t2_done_a_off", 32'(done_a), 0);
    check_eq("t2_quo_b", 32'(quotient_out), 2);
    check_eq("t2_rem_b", 32'(remainder_out), 1);
    check_eq("t2_err_b", 32'(error_b), 0);
    div_done = 0; req_b = 0;
    tick();  // IDLE, A still requesting
    tick();  // ISSUE for A again
    check_eq("t2_gnt_a3", 32'(gnt_a), 1);
    check_eq("t2_dvd_a3", 32'(div_dividend), 50);
    tick();
    div_done = 1; div_quotient = 8'd10; div_remainder = 8'd0;
    tick();  // RESP
    check_eq("t2_done_a3", 32'(done_a), 1);
    div_done = 0; req_a = 0;
    tick();

    // 3: B divide-by-zero, done at grant+2, no start
    start_base = n_start;
    req_b = 1; dividend_b = 8'd9; divisor_b = 8'd0;
    tick();  // ISSUE
    check_eq("t3_start", 32'(div_start), 0);
    check_eq("t3_gnt_b", 32'(gnt_b), 1);
    check_eq("t3_done_early", 32'(done_b), 0);
    tick();  // RESP
    check_eq("t3_done_b", 32'(done_b), 1);
    check_eq("t3_err_b", 32'(error_b), 1);
    check_eq("t3_err_a", 32'(error_a), 0);
    check_eq("t3_quo", 32'(quotient_out), 0);
    check_eq("t3_rem", 32'(remainder_out), 0);
    req_b = 0;
    tick();
    check_eq("t3_nstart", 32'(n_start - start_base), 0);

    // 4: divider hangs; abort TIMEOUT cycles after start, late done ignored
    req_a = 1; dividend_a = 8'd20; divisor_a = 8'd3;
    tick();  // ISSUE (start)
    check_eq("t4_start", 32'(div_start), 1);
    repeat (TIMEOUT - 1) tick();
    check_eq("t4_not_yet", 32'(done_a), 0);
    check_eq("t4_busy", 32'(busy), 1);
    tick();  // RESP at start + TIMEOUT
    check_eq("t4_done_a", 32'(done_a), 1);
    check_eq("t4_err_a", 32'(error_a), 1);
    check_eq("t4_quo", 32'(quotient_out), 0);
    req_a = 0;
    div_done = 1; div_quotient = 8'd55; div_remainder = 8'd9;
    tick();  // IDLE
    check_eq("t4_busy_off", 32'(busy), 0);
    check_eq("t4_late_quo", 32'(quotient_out), 0);
    check_eq("t4_late_done", 32'(done_a), 0);
    div_done = 0;
    tick();
    check_eq("t4_idle", 32'(busy), 0);

    // 5: async reset mid-BUSY, then a clean restart
    start_base = n_start;
    req_a = 1; dividend_a = 8'd100; divisor_a = 8'd7;
    tick();  // ISSUE
    tick();  // BUSY
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_gnt_a", 32'(gnt_a), 0);
    check_eq("t5_dvd", 32'(div_dividend), 0);
    check_eq("t5_dvs", 32'(div_divisor), 0);
    tick();
    check_eq("t5_start_held", 32'(div_start), 0);
    reset = 1'b1;
    tick();  // ISSUE after restart
    check_eq("t5_restart", 32'(div_start), 1);
    check_eq("t5_gnt_a2", 32'(gnt_a), 1);
    tick();  // BUSY
    check_eq("t5_single", 32'(div_start), 0);
    div_done = 1; div_quotient = 8'd14; div_remainder = 8'd2;
    tick();  // RESP
    check_eq("t5_done_a", 32'(done_a), 1);
    check_eq("t5_quo", 32'(quotient_out), 14);
    div_done = 0; req_a = 0;
    tick();
    check_eq("t5_nstart", 32'(n_start - start_base), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
